seg_scan4: RTL and testbench
============================

# seg_scan4

Four-digit multiplexed 7-segment display stage for the Tang Nano 9k (27 MHz) designs. It accepts a binary value over a valid/ready handshake and converts it to BCD with a sequential shift-add-3 (double-dabble) engine. It stores the four digits in a display buffer and time-multiplexes them onto a shared segment bus with active-low digit enables. It sits directly downstream of counter blocks such as the 0–99 counter and replaces their per-block digit decode and scan logic with one shared display back end.

## Interface
- SCAN_WAIT, 27_000, i_clk cycles per digit slot (1 ms at 27 MHz); legal range ≥ 2
- MAX_VAL, 9999, saturation limit applied at capture
- i_clk  in  1  clock
- w_rst  in  1  reset w_rst, asynchronous, active-high; clock i_clk
- i_val  in  14  binary value to display
- i_dp  in  4  decimal-point enables, bit n = digit n (0 = ones)
- i_valid  in  1  i_val/i_dp valid
- o_ready  out  1  high when the converter can accept a value
- o_seg  out  8  segments {a,b,c,d,e,f,g,dp}, a = bit 7, 1 = lit
- o_dig  out  4  digit enables, active-low, bit 0 = ones digit

## Operation
- Converter FSM states:
  - IDLE: o_ready = 1. On i_valid & o_ready, capture min(i_val, MAX_VAL) and i_dp, clear the 16-bit BCD accumulator, go to SHIFT.
  - SHIFT: 14 iterations, one per cycle. Each iteration adds 3 to every BCD nibble ≥ 5, then shifts {bcd, bin} left by 1. After the 14th iteration go to DONE.
  - DONE: copy the BCD result and dp bits to the display buffer, go to IDLE.
- o_ready is combinational from state == IDLE.
- i_valid is ignored outside IDLE. The producer holds its value until it is accepted.
- Scan logic:
  - A prescaler counts 0..SCAN_WAIT-1.
  - At the terminal count the digit index advances 0→1→2→3→0.
  - o_dig and o_seg are registered and update in the same cycle as the index.
  - o_dig = ~(1 << idx).
  - o_seg = decode(buffer[idx]) | {7'b0, dp[idx]}.
- Decode values 0–9: FC, 60, DA, F2, 66, B6, BE, E0, FE, F6 (hex). Codes 10–15 are unreachable and decode to 00.
- The scan runs continuously and independently of the converter. A buffer update is visible at the next o_seg register update.

## Timing
- Reset values:
  - state IDLE, o_ready 1
  - buffer all zero, dp 0
  - idx 0, prescaler 0
  - o_dig 4'b1110, o_seg 8'hFC
- Handshake latency. With acceptance at edge T:
  - SHIFT occupies edges T+1..T+14.
  - DONE writes the buffer at edge T+15.
  - o_ready is low from after T until after T+15, and high again in the cycle following edge T+15.
  - Peak throughput is 1 value per 16 cycles.
- Saturation: i_val > MAX_VAL (up to 16383) is clamped at capture, with no error flag.
- Wrap-around: idx 3 → 0 and prescaler SCAN_WAIT-1 → 0 occur on the same edge.
- Reset asserted mid-conversion: the conversion is aborted, the buffer returns to 0, and o_ready is high while reset is held.
- Buffer write and digit advance on the same edge: the new o_seg uses the old buffer. The new contents appear at the next advance.

## Configuration
- SEG_LZB_EN defined (leading-zero blanking):
  - Thousands, hundreds and tens digits output o_seg = 8'h00 when that digit and every higher digit are zero.
  - The dp bit is still ORed in.
  - The ones digit is never blanked.
- SEG_LZB_EN undefined: every digit is always decoded. Value 7 shows "0007".

## Structure
- Package seg_pkg holds:
  - SEG_0..SEG_9 and SEG_BLANK constants
  - NDIG = 4
  - the converter state enum (IDLE, SHIFT, DONE)
  - the iteration-count width
- One sub-module, bin2bcd_seq:
  - contains the FSM, the double-dabble datapath and the valid/ready handshake
  - outputs 16-bit BCD plus a one-cycle done strobe
- The top level holds the display buffer, the prescaler, the digit index and the output registers.

## Test plan
All scan checks use SCAN_WAIT = 4.
1. Assert w_rst → o_seg 8'hFC, o_dig 4'b1110, o_ready 1. Release → the index advances every 4 cycles with o_seg FC on all digits.
2. Send i_val 1234 with i_valid for 1 cycle → o_ready low for 15 cycles. Scan then shows o_dig 1110/1101/1011/0111 with o_seg 66/F2/DA/60.
3. Send i_val 12000 → saturated to 9999, all four digits show F6.
4. Send i_val 7 with i_dp 4'b0010:
   - SEG_LZB_EN: digit0 E0, digit1 01, digits 2–3 00.
   - Without the macro: digit1 FD, digits 2–3 FC.
5. Send 42, then hold i_valid with 56 while busy → 56 is accepted exactly 16 cycles after 42, and the final display is 0056 (or 56 when blanked).
6. Send 1234, then assert w_rst 5 cycles after acceptance → after release the buffer is 0, all digits show FC, and o_ready is 1.

Source files
------------

// File: rtl/seg_pkg.sv
// seg_pkg: shared constants, types and helpers for the seg_scan4 display stage.
//   SEG_0..SEG_9, SEG_BLANK : segment codes {a,b,c,d,e,f,g,dp}, a = bit 7, 1 = lit
//   NDIG                    : number of multiplexed digits
//   BIN_W / BCD_W           : binary input width and packed BCD width
//   ITER / CNT_W            : double-dabble iteration count and its counter width
//   conv_state_t            : converter FSM states
//   seg_decode()            : BCD digit to segment code (10..15 decode blank)
//   bcd_add3()              : per-nibble "add 3 if >= 5" correction step
package seg_pkg;

    localparam int NDIG  = 4;
    localparam int BIN_W = 14;
    localparam int BCD_W = 16;
    localparam int ITER  = 14;
    localparam int CNT_W = 4;

    localparam logic [7:0] SEG_0     = 8'hFC;
    localparam logic [7:0] SEG_1     = 8'h60;
    localparam logic [7:0] SEG_2     = 8'hDA;
    localparam logic [7:0] SEG_3     = 8'hF2;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'hB6;
    localparam logic [7:0] SEG_6     = 8'hBE;
    localparam logic [7:0] SEG_7     = 8'hE0;
    localparam logic [7:0] SEG_8     = 8'hFE;
    localparam logic [7:0] SEG_9     = 8'hF6;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    function automatic logic [7:0] seg_decode(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Applied before every shift so a nibble that would reach >= 10 after
    // doubling carries correctly into the next decade.
    function automatic logic [15:0] bcd_add3(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int n = 0; n < 4; n++) begin
            if (b[n*4 +: 4] >= 4'd5) begin
                r[n*4 +: 4] = b[n*4 +: 4] + 4'd3;
            end else begin
                r[n*4 +: 4] = b[n*4 +: 4];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seg_scan4_if.sv
// seg_scan4_if: valid/ready value handshake into the display stage.
//   i_val   : binary value to display
//   i_dp    : decimal-point enables, bit n = digit n (0 = ones)
//   i_valid : i_val/i_dp valid
//   o_ready : converter can accept a value
// master = producer (counter block), slave = seg_scan4.
interface seg_scan4_if;
    import seg_pkg::*;

    logic [BIN_W-1:0] i_val;
    logic [3:0]       i_dp;
    logic             i_valid;
    logic             o_ready;

    modport master (output i_val, output i_dp, output i_valid, input o_ready);
    modport slave  (input i_val, input i_dp, input i_valid, output o_ready);
endinterface

// File: rtl/seg_scan4_bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-add-3 binary to BCD converter with handshake.
//   i_clk  : clock
//   w_rst  : asynchronous active-high reset
//   s_in   : value handshake (slave side); o_ready is high in IDLE
//   o_bcd  : 16-bit packed BCD result (valid while o_done is high)
//   o_dp   : decimal-point bits captured with the value
//   o_done : one-cycle strobe, high in the DONE state
// Acceptance at edge T -> SHIFT on edges T+1..T+14 -> DONE cycle after T+14.
module bin2bcd_seq
    import seg_pkg::*;
#(
    parameter int MAX_VAL = 9999
) (
    input  logic              i_clk,
    input  logic              w_rst,
    seg_scan4_if.slave        s_in,
    output logic [BCD_W-1:0]  o_bcd,
    output logic [3:0]        o_dp,
    output logic              o_done
);

    localparam logic [BIN_W-1:0] MAX_V    = BIN_W'(MAX_VAL);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    conv_state_t      r_state;
    logic [BIN_W-1:0] r_bin;
    logic [BCD_W-1:0] r_bcd;
    logic [3:0]       r_dp;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done;

    logic [BIN_W-1:0] w_clamp;
    logic [BCD_W-1:0] w_adj;

    assign s_in.o_ready = (r_state == IDLE);
    assign o_bcd        = r_bcd;
    assign o_dp         = r_dp;
    assign o_done       = r_done;

    // Saturate the incoming value and form the corrected BCD for this iteration.
    always_comb begin
        w_clamp = (s_in.i_val > MAX_V) ? MAX_V : s_in.i_val;
        w_adj   = bcd_add3(r_bcd);
    end

    // Converter FSM and double-dabble datapath.
    always_ff @(posedge i_clk or posedge w_rst) begin
        if (w_rst) begin
            r_state <= IDLE;
            r_bin   <= {BIN_W{1'b0}};
            r_bcd   <= {BCD_W{1'b0}};
            r_dp    <= 4'b0000;
            r_cnt   <= {CNT_W{1'b0}};
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (s_in.i_valid) begin
                        r_bin   <= w_clamp;
                        r_dp    <= s_in.i_dp;
                        r_bcd   <= {BCD_W{1'b0}};
                        r_cnt   <= {CNT_W{1'b0}};
                        r_state <= SHIFT;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                SHIFT: begin
                    // The BCD top bit shifted out is always zero for values <= 9999.
                    {r_bcd, r_bin} <= {w_adj[BCD_W-2:0], r_bin, 1'b0};
                    r_cnt          <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_LAST) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= SHIFT;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/seg_scan4.sv
// seg_scan4: four-digit multiplexed 7-segment display back end.
//   i_clk : clock (27 MHz on Tang Nano 9k)
//   w_rst : asynchronous active-high reset
//   s_in  : value handshake (slave side), see seg_scan4_if
//   o_seg : registered segments {a,b,c,d,e,f,g,dp}, 1 = lit
//   o_dig : registered active-low digit enables, bit 0 = ones digit
// Parameters: SCAN_WAIT (cycles per digit slot, >= 2), MAX_VAL (saturation).
// Optional build macro SEG_LZB_EN: leading-zero blanking of the upper three
// digits (dp still shown, ones digit never blanked).
module seg_scan4
    import seg_pkg::*;
#(
    parameter int SCAN_WAIT = 27_000,
    parameter int MAX_VAL   = 9999
) (
    input  logic        i_clk,
    input  logic        w_rst,
    seg_scan4_if.slave  s_in,
    output logic [7:0]  o_seg,
    output logic [3:0]  o_dig
);

    localparam int               PRE_W    = $clog2(SCAN_WAIT);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_WAIT - 1);

    logic [BCD_W-1:0] w_bcd;
    logic [3:0]       w_cdp;
    logic             w_done;

    logic [BCD_W-1:0] r_buf;
    logic [3:0]       r_dp;
    logic [PRE_W-1:0] r_pre;
    logic [1:0]       r_idx;

    logic [1:0]       w_idx_nxt;
    logic [3:0]       w_nib;
    logic             w_blank;
    logic [7:0]       w_seg_nxt;
    logic [3:0]       w_dig_nxt;

    bin2bcd_seq #(
        .MAX_VAL (MAX_VAL)
    ) u_conv (
        .i_clk  (i_clk),
        .w_rst  (w_rst),
        .s_in   (s_in),
        .o_bcd  (w_bcd),
        .o_dp   (w_cdp),
        .o_done (w_done)
    );

    // Display buffer, loaded once per finished conversion.
    always_ff @(posedge i_clk or posedge w_rst) begin
        if (w_rst) begin
            r_buf <= {BCD_W{1'b0}};
            r_dp  <= 4'b0000;
        end else if (w_done) begin
            r_buf <= w_bcd;
            r_dp  <= w_cdp;
        end else begin
            r_buf <= r_buf;
            r_dp  <= r_dp;
        end
    end

    // Pattern for the slot about to be shown; reads the buffer as it stands
    // before this edge, so a same-edge buffer write shows at the next slot.
    always_comb begin
        w_idx_nxt = r_idx + 2'd1;
        w_nib     = r_buf[{w_idx_nxt, 2'b00} +: 4];
`ifdef SEG_LZB_EN
        case (w_idx_nxt)
            2'd3:    w_blank = (r_buf[15:12] == 4'd0);
            2'd2:    w_blank = (r_buf[15:8]  == 8'd0);
            2'd1:    w_blank = (r_buf[15:4]  == 12'd0);
            default: w_blank = 1'b0;
        endcase
`else
        w_blank = 1'b0;
`endif
        w_seg_nxt = (w_blank ? SEG_BLANK : seg_decode(w_nib)) | {7'b0000000, r_dp[w_idx_nxt]};
        w_dig_nxt = ~(4'b0001 << w_idx_nxt);
    end

    // Prescaler, digit index and output registers; index and outputs move together.
    always_ff @(posedge i_clk or posedge w_rst) begin
        if (w_rst) begin
            r_pre <= {PRE_W{1'b0}};
            r_idx <= 2'd0;
            o_dig <= 4'b1110;
            o_seg <= SEG_0;
        end else if (r_pre == PRE_LAST) begin
            r_pre <= {PRE_W{1'b0}};
            r_idx <= w_idx_nxt;
            o_dig <= w_dig_nxt;
            o_seg <= w_seg_nxt;
        end else begin
            r_pre <= r_pre + PRE_W'(1);
            r_idx <= r_idx;
            o_dig <= o_dig;
            o_seg <= o_seg;
        end
    end

endmodule

// File: tb/tb_seg_scan4.sv
// tb_seg_scan4: directed + randomized self-checking bench for seg_scan4
// (SCAN_WAIT = 4). The reference model computes each digit's expected
// segment pattern from the decimal value with plain arithmetic.
module tb_seg_scan4;

    logic       i_clk = 1'b0;
    logic       w_rst;
    logic [7:0] o_seg;
    logic [3:0] o_dig;

    int checks = 0;
    int errors = 0;

    seg_scan4_if bus ();

    seg_scan4 #(
        .SCAN_WAIT (4),
        .MAX_VAL   (9999)
    ) dut (
        .i_clk (i_clk),
        .w_rst (w_rst),
        .s_in  (bus),
        .o_seg (o_seg),
        .o_dig (o_dig)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [7:0] code_of(input int d);
        case (d)
            0: return 8'hFC;
            1: return 8'h60;
            2: return 8'hDA;
            3: return 8'hF2;
            4: return 8'h66;
            5: return 8'hB6;
            6: return 8'hBE;
            7: return 8'hE0;
            8: return 8'hFE;
            9: return 8'hF6;
            default: return 8'h00;
        endcase
    endfunction

    // Expected o_seg for digit n when value v (before clamping) is displayed.
    function automatic logic [7:0] exp_seg(input int v, input logic [3:0] dp, input int n);
        int cv;
        int p;
        logic [7:0] s;
        cv = (v > 9999) ? 9999 : v;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        s = code_of((cv / p) % 10);
`ifdef SEG_LZB_EN
        if (n > 0 && cv < p) s = 8'h00;
`endif
        return s | {7'b0000000, dp[n]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Present a value, wait for acceptance, then measure the busy window.
    task automatic send(input int v, input logic [3:0] dp);
        int n;
        bus.i_val   = 14'(v);
        bus.i_dp    = dp;
        bus.i_valid = 1'b1;
        n = 0;
        while (!bus.o_ready && n < 50) begin
            step();
            n++;
        end
        chk("accept_wait", 32'(n < 50), 32'd1);
        step();
        bus.i_valid = 1'b0;
        n = 0;
        while (!bus.o_ready && n < 40) begin
            step();
            n++;
        end
        chk("ready_low_cycles", 32'(n), 32'd15);
    endtask

    // Watch the next four digit advances and compare each against the model.
    task automatic check_slots(input int v, input logic [3:0] dp, input string tag);
        int cyc;
        int idx;
        int prev_idx;
        logic [3:0] prev;
        prev_idx = -1;
        for (int k = 0; k < 4; k++) begin
            prev = o_dig;
            cyc  = 0;
            do begin
                step();
                cyc++;
            end while (o_dig === prev && cyc < 20);
            chk({tag, "_advance"}, 32'(cyc < 20), 32'd1);
            idx = -1;
            for (int i = 0; i < 4; i++) begin
                if (o_dig === ~(4'b0001 << i)) idx = i;
            end
            chk({tag, "_dig_onehot"}, 32'(idx >= 0), 32'd1);
            if (idx >= 0) begin
                chk({tag, "_seg"}, {24'd0, o_seg}, {24'd0, exp_seg(v, dp, idx)});
            end
            if (k > 0) begin
                chk({tag, "_period"}, 32'(cyc), 32'd4);
                chk({tag, "_order"}, 32'(idx), 32'((prev_idx + 1) % 4));
            end
            prev_idx = idx;
        end
    endtask

    initial begin
        int n;
        int v;
        logic [3:0] dp;

        // 1: reset state and idle scan
        w_rst       = 1'b1;
        bus.i_val   = 14'd0;
        bus.i_dp    = 4'd0;
        bus.i_valid = 1'b0;
        #12;
        chk("rst_seg", {24'd0, o_seg}, 32'h0000_00FC);
        chk("rst_dig", {28'd0, o_dig}, 32'h0000_000E);
        chk("rst_ready", {31'd0, bus.o_ready}, 32'd1);
        step();
        w_rst = 1'b0;
        check_slots(0, 4'b0000, "idle");

        // 2..4: directed values
        send(1234, 4'b0000);
        check_slots(1234, 4'b0000, "v1234");
        send(12000, 4'b0000);
        check_slots(12000, 4'b0000, "sat12000");
        send(7, 4'b0010);
        check_slots(7, 4'b0010, "v7dp");
        send(16383, 4'b1111);
        check_slots(16383, 4'b1111, "sat16383");
        send(0, 4'b0001);
        check_slots(0, 4'b0001, "zero");

        // 5: second value held while busy is taken exactly 16 cycles later
        bus.i_val   = 14'd42;
        bus.i_dp    = 4'd0;
        bus.i_valid = 1'b1;
        step();
        bus.i_val = 14'd56;
        n = 0;
        while (!bus.o_ready && n < 40) begin
            step();
            n++;
        end
        chk("back2back_gap", 32'(n + 1), 32'd16);
        step();
        bus.i_valid = 1'b0;
        n = 0;
        while (!bus.o_ready && n < 40) begin
            step();
            n++;
        end
        chk("back2back_busy", 32'(n), 32'd15);
        check_slots(56, 4'b0000, "v56");

        // randomized values
        for (int r = 0; r < 6; r++) begin
            v  = int'($urandom_range(0, 16383));
            dp = 4'($urandom_range(0, 15));
            send(v, dp);
            check_slots(v, dp, "rand");
        end

        // 6: reset in the middle of a conversion
        bus.i_val   = 14'd1234;
        bus.i_dp    = 4'b0100;
        bus.i_valid = 1'b1;
        step();
        bus.i_valid = 1'b0;
        chk("busy_before_rst", {31'd0, bus.o_ready}, 32'd0);
        for (int i = 0; i < 4; i++) step();
        w_rst = 1'b1;
        #1;
        chk("midrst_ready", {31'd0, bus.o_ready}, 32'd1);
        chk("midrst_seg", {24'd0, o_seg}, 32'h0000_00FC);
        chk("midrst_dig", {28'd0, o_dig}, 32'h0000_000E);
        step();
        chk("midrst_ready_held", {31'd0, bus.o_ready}, 32'd1);
        w_rst = 1'b0;
        step();
        chk("post_rst_ready", {31'd0, bus.o_ready}, 32'd1);
        check_slots(0, 4'b0000, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
